imem_loader: RTL and testbench
==============================

# imem_loader

Sequential writer for the processor's byte-addressable, little-endian instruction memory. It accepts 32-bit instruction words on a valid/ready stream and serializes each word into four byte writes on the memory's byte write port, starting at byte address 0. It holds the pipeline in CPU_HOLD while loading, so the combinational fetch read never observes a partially written program. It sits between the program source (testbench or host link) and the instruction memory's write port.

## Interface
- BYTE_SIZE, 4, bytes per instruction word
- ADDR_WIDTH, 12, byte address width
- MEM_BYTES, 48, instruction memory capacity in bytes (multiple of BYTE_SIZE)
- CLK  input  1  clock; all state updates on rising edge
- RESET_N  input  1  asynchronous, active-low reset
- START  input  1  single-cycle pulse: begin a new load at address 0
- WD_VALID  input  1  source has a word on WD
- WD  input  8*BYTE_SIZE  instruction word
- WD_LAST  input  1  qualifies WD as final word of the program
- WD_READY  output  1  loader accepts WD this cycle
- WE  output  1  byte write enable to instruction memory
- WA  output  ADDR_WIDTH  byte write address
- WB  output  8  byte write data
- BUSY  output  1  load in progress
- CPU_HOLD  output  1  stall/hold request to processor (equals BUSY)
- DONE  output  1  load finished; held until next START
- ERR  output  1  overflow: word offered beyond MEM_BYTES
- WORD_COUNT  output  ADDR_WIDTH  words written in current/last load

## Operation
- FSM states: IDLE, ACCEPT, WRITE, FIN.
- IDLE: WD_READY=0. START -> ACCEPT; base address, WORD_COUNT, ERR cleared.
- ACCEPT: WD_READY=1. Handshake when WD_VALID && WD_READY: latch WD and WD_LAST.
  - base+BYTE_SIZE <= MEM_BYTES: -> WRITE, byte index 0.
  - otherwise: word dropped, ERR=1, -> FIN.
- WRITE: WE=1, WA=base+idx, WB=word[8*idx +: 8] (little endian: byte 0 = bits 7:0 at lowest address). idx increments each cycle. On idx=BYTE_SIZE-1: base+=BYTE_SIZE, WORD_COUNT+=1; latched LAST -> FIN, else -> ACCEPT.
- FIN: DONE=1. START -> ACCEPT (new load, counters cleared). START in FIN and IDLE is the only accepted START.
- START during ACCEPT or WRITE: ignored.
- Address arithmetic is ADDR_WIDTH-bit unsigned; overflow check uses a width of ADDR_WIDTH+1 so it never wraps.
- BUSY = CPU_HOLD = (state is ACCEPT or WRITE).

## Timing
- Reset values: state IDLE, WD_READY=0, WE=0, WA=0, WB=0, BUSY=0, CPU_HOLD=0, DONE=0, ERR=0, WORD_COUNT=0.
- START at edge N -> ACCEPT, WD_READY=1 in cycle N+1.
- Handshake at edge H -> WE high in cycles H+1..H+BYTE_SIZE, WD_READY low in those cycles, WD_READY high again in cycle H+BYTE_SIZE+1 (non-last word).
- Throughput: one word per BYTE_SIZE+1 cycles.
- Last word: DONE=1 and BUSY=0 in cycle H+BYTE_SIZE+1.
- The memory writes WB at WA on the rising edge while WE=1; WE, WA, and WB are registered outputs.
- RESET_N low mid-load: immediate return to reset values, with no further WE. Memory contents written so far are left as-is.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: adds output CHECKSUM [7:0], the mod-256 sum of every byte written with WE=1. It is cleared on accepted START and on reset, and is stable once DONE=1.
- Macro undefined: no CHECKSUM port and no adder.

## Structure
- Package imem_pkg: FSM state enum (IDLE, ACCEPT, WRITE, FIN), default MEM_BYTES, INSTR_BYTES=4.
- One sub-module, imem_byte_serializer, handles the latched word, byte index, and the WE/WA/WB registers. It receives load/base and reports a last-byte strobe. The FSM, counters, and ERR live in the top.

## Test plan
- Reset, then START, then one word 0xE3A01005 with LAST -> writes bytes 05,10,A0,E3 at WA=0..3 on consecutive cycles; DONE=1 and WORD_COUNT=1 in the next cycle.
- 12 words back-to-back with VALID held high, last flagged -> 48 byte writes, WA 0..47; WD_READY gaps of exactly 4 cycles; no ERR.
- 13th word without LAST after 12 -> word not written, ERR=1, DONE=1, WORD_COUNT=12.
- WD_VALID toggling randomly and START pulses during ACCEPT/WRITE -> byte sequence and addresses unchanged, and START is ignored.
- RESET_N asserted during the 3rd byte write -> WE drops immediately and all outputs return to reset values; a new START reloads from address 0.
- With IMEM_LOADER_CHECKSUM_EN, words 0x01020304 and 0xFFFFFFFF -> CHECKSUM=0x06 at DONE.

Source files
------------

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and defaults for the instruction-memory loader.
// Optional feature macro used by imem_loader: IMEM_LOADER_CHECKSUM_EN.
package imem_pkg;

  // Bytes per instruction word and default memory capacity in bytes.
  localparam int INSTR_BYTES   = 4;
  localparam int DEF_MEM_BYTES = 48;

  // Loader FSM states.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCEPT = 2'd1,
    WRITE  = 2'd2,
    FIN    = 2'd3
  } imem_state_e;

endpackage : imem_pkg

// File: rtl/imem_byte_serializer.sv
// imem_byte_serializer: latches one instruction word and emits it as
// BYTE_SIZE little-endian byte writes (lowest byte at the lowest address)
// on consecutive cycles. WE/WA/WB are registered. last_byte flags the cycle
// in which the final byte of the word is on the write port.
module imem_byte_serializer
  import imem_pkg::*;
#(
  parameter int BYTE_SIZE  = INSTR_BYTES,
  parameter int ADDR_WIDTH = 12
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [8*BYTE_SIZE-1:0] word,
  input  logic [ADDR_WIDTH-1:0]  base,
  output logic                   we,
  output logic [ADDR_WIDTH-1:0]  wa,
  output logic [7:0]             wb,
  output logic                   last_byte
);

  localparam int            IW       = (BYTE_SIZE > 1) ? $clog2(BYTE_SIZE) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(BYTE_SIZE - 1);

  logic [IW-1:0]          idx;
  // Remaining bytes of the word, next byte always in bits [7:0].
  logic [8*BYTE_SIZE-1:0] sh;

  assign last_byte = we && (idx == IDX_LAST);

  // Load puts byte 0 on the port at once; each following cycle steps to the
  // next byte/address until the last byte has been presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      sh  <= '0;
      we  <= 1'b0;
      wa  <= '0;
      wb  <= '0;
    end else if (load) begin
      idx <= '0;
      sh  <= word >> 8;
      we  <= 1'b1;
      wa  <= base;
      wb  <= word[7:0];
    end else if (we) begin
      if (idx == IDX_LAST) begin
        we <= 1'b0;
      end else begin
        idx <= idx + 1'b1;
        wa  <= wa + 1'b1;
        wb  <= sh[7:0];
        sh  <= sh >> 8;
      end
    end
  end

endmodule : imem_byte_serializer

// File: rtl/imem_loader.sv
// imem_loader: accepts instruction words on a valid/ready stream and writes
// them byte by byte into the instruction memory from address 0, holding the
// CPU while a load is in progress. Words that would not fit set ERR.
// Optional macro IMEM_LOADER_CHECKSUM_EN adds a mod-256 CHECKSUM output of
// every byte written.
module imem_loader
  import imem_pkg::*;
#(
  parameter int BYTE_SIZE  = INSTR_BYTES,
  parameter int ADDR_WIDTH = 12,
  parameter int MEM_BYTES  = DEF_MEM_BYTES
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   START,
  input  logic                   WD_VALID,
  input  logic [8*BYTE_SIZE-1:0] WD,
  input  logic                   WD_LAST,
  output logic                   WD_READY,
  output logic                   WE,
  output logic [ADDR_WIDTH-1:0]  WA,
  output logic [7:0]             WB,
  output logic                   BUSY,
  output logic                   CPU_HOLD,
  output logic                   DONE,
  output logic                   ERR,
`ifdef IMEM_LOADER_CHECKSUM_EN
  output logic [7:0]             CHECKSUM,
`endif
  output logic [ADDR_WIDTH-1:0]  WORD_COUNT
);

  localparam logic [1:0] S_IDLE   = 2'(IDLE);
  localparam logic [1:0] S_ACCEPT = 2'(ACCEPT);
  localparam logic [1:0] S_WRITE  = 2'(WRITE);
  localparam logic [1:0] S_FIN    = 2'(FIN);

  // Overflow check runs one bit wider than the address so it never wraps.
  localparam logic [ADDR_WIDTH:0]   STEP_W  = (ADDR_WIDTH+1)'(BYTE_SIZE);
  localparam logic [ADDR_WIDTH:0]   LIMIT_W = (ADDR_WIDTH+1)'(MEM_BYTES);
  localparam logic [ADDR_WIDTH-1:0] STEP_A  = ADDR_WIDTH'(BYTE_SIZE);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [ADDR_WIDTH-1:0] wcount;
  logic                  err_q;
  logic                  last_q;
  logic                  hs;
  logic                  fits;
  logic                  load;
  logic                  start_ok;
  logic                  ser_last;
  logic [ADDR_WIDTH:0]   word_end;

  assign WD_READY   = (state == S_ACCEPT);
  assign BUSY       = (state == S_ACCEPT) || (state == S_WRITE);
  assign CPU_HOLD   = BUSY;
  assign DONE       = (state == S_FIN);
  assign ERR        = err_q;
  assign WORD_COUNT = wcount;

  assign hs       = WD_VALID && WD_READY;
  assign word_end = {1'b0, base} + STEP_W;
  assign fits     = (word_end <= LIMIT_W);
  assign load     = hs && fits;
  // START is honoured only between loads.
  assign start_ok = START && ((state == S_IDLE) || (state == S_FIN));

  imem_byte_serializer #(
    .BYTE_SIZE  (BYTE_SIZE),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ser (
    .clk       (CLK),
    .rst_n     (RESET_N),
    .load      (load),
    .word      (WD),
    .base      (base),
    .we        (WE),
    .wa        (WA),
    .wb        (WB),
    .last_byte (ser_last)
  );

  // Load FSM with base address, word counter and overflow flag.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state  <= S_IDLE;
      base   <= '0;
      wcount <= '0;
      err_q  <= 1'b0;
      last_q <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_FIN: begin
          if (start_ok) begin
            state  <= S_ACCEPT;
            base   <= '0;
            wcount <= '0;
            err_q  <= 1'b0;
            last_q <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (hs) begin
            last_q <= WD_LAST;
            if (fits) begin
              state <= S_WRITE;
            end else begin
              err_q <= 1'b1;
              state <= S_FIN;
            end
          end
        end
        S_WRITE: begin
          if (ser_last) begin
            base   <= base + STEP_A;
            wcount <= wcount + 1'b1;
            state  <= last_q ? S_FIN : S_ACCEPT;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;
  assign CHECKSUM = csum;

  // Running mod-256 sum of every byte the memory actually takes.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      csum <= '0;
    end else if (start_ok) begin
      csum <= '0;
    end else if (WE) begin
      csum <= csum + WB;
    end
  end
`endif

endmodule : imem_loader

// File: tb/tb_imem_loader.sv
// tb_imem_loader: scoreboard bench. Stimulus pushes expected byte writes
// into a queue; a monitor pops and compares on every WE cycle.
module tb_imem_loader;

  localparam int BS = 4;
  localparam int AW = 12;
  localparam int MB = 48;

  logic          CLK;
  logic          RESET_N;
  logic          START;
  logic          WD_VALID;
  logic [8*BS-1:0] WD;
  logic          WD_LAST;
  logic          WD_READY;
  logic          WE;
  logic [AW-1:0] WA;
  logic [7:0]    WB;
  logic          BUSY;
  logic          CPU_HOLD;
  logic          DONE;
  logic          ERR;
  logic [AW-1:0] WORD_COUNT;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    CHECKSUM;
`endif

  imem_loader #(.BYTE_SIZE(BS), .ADDR_WIDTH(AW), .MEM_BYTES(MB)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .START      (START),
    .WD_VALID   (WD_VALID),
    .WD         (WD),
    .WD_LAST    (WD_LAST),
    .WD_READY   (WD_READY),
    .WE         (WE),
    .WA         (WA),
    .WB         (WB),
    .BUSY       (BUSY),
    .CPU_HOLD   (CPU_HOLD),
    .DONE       (DONE),
    .ERR        (ERR),
`ifdef IMEM_LOADER_CHECKSUM_EN
    .CHECKSUM   (CHECKSUM),
`endif
    .WORD_COUNT (WORD_COUNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [7:0]    d;
  } wr_t;

  wr_t exp_q[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  ebase = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every byte the memory takes must match the next expected write.
  always @(negedge CLK) begin
    wr_t e;
    if (WE === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got WA=%0d WB=%h expected no write", WA, WB);
      end else begin
        e = exp_q.pop_front();
        chk("byte_write{WA,WB}", {12'h0, WA, WB}, {12'h0, e.a, e.d});
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, {31'h0, WD_READY}, 32'h0);
    chk({tag, "_we"},    {31'h0, WE},       32'h0);
    chk({tag, "_wa"},    {20'h0, WA},       32'h0);
    chk({tag, "_wb"},    {24'h0, WB},       32'h0);
    chk({tag, "_busy"},  {31'h0, BUSY},     32'h0);
    chk({tag, "_hold"},  {31'h0, CPU_HOLD}, 32'h0);
    chk({tag, "_done"},  {31'h0, DONE},     32'h0);
    chk({tag, "_err"},   {31'h0, ERR},      32'h0);
    chk({tag, "_wcnt"},  {20'h0, WORD_COUNT}, 32'h0);
  endtask

  // Offer one word; returns after the handshake edge. nbytes expected writes
  // are queued at the running base. rnd randomises VALID and START while waiting.
  task automatic send(input logic [31:0] w, input logic last, input logic rnd,
                      input int nbytes, output int gap);
    int cyc;
    bit ok;
    cyc = 0;
    ok  = 0;
    WD      = w;
    WD_LAST = last;
    while (!ok && cyc <= 50) begin
      if (rnd) begin
        WD_VALID = 1'($urandom_range(0, 1));
        START    = 1'($urandom_range(0, 1));
      end else begin
        WD_VALID = 1'b1;
      end
      if (WD_VALID && WD_READY) ok = 1;
      else begin
        tick();
        cyc++;
      end
    end
    gap = cyc;
    if (!ok) begin
      n_cmp++;
      n_bad++;
      $display("FAIL handshake_timeout: got no WD_READY expected handshake within 50 cycles");
      WD_VALID = 1'b0;
      START    = 1'b0;
    end else begin
      for (int b = 0; b < nbytes; b++) begin
        exp_q.push_back('{a: AW'(ebase + b), d: w[8*b +: 8]});
      end
      ebase += BS;
      tick();
      START = 1'b0;
      if (rnd) WD_VALID = 1'b0;
    end
  endtask

  initial begin
    int gap;
    logic [31:0] w;
    RESET_N  = 1'b0;
    START    = 1'b0;
    WD_VALID = 1'b0;
    WD       = '0;
    WD_LAST  = 1'b0;
    #20000000;
  end

  initial begin
    int gap;
    logic [31:0] w;
    #2;
    // Reset state
    tick();
    check_reset_vals("reset");
    RESET_N = 1'b1;
    tick();

    // Single word with LAST
    do_start();
    chk("t1_ready_after_start", {31'h0, WD_READY}, 32'h1);
    chk("t1_busy_after_start",  {31'h0, BUSY}, 32'h1);
    chk("t1_hold_after_start",  {31'h0, CPU_HOLD}, 32'h1);
    ebase = 0;
    send(32'hE3A01005, 1'b1, 1'b0, BS, gap);
    WD_VALID = 1'b0;
    chk("t1_ready_during_write", {31'h0, WD_READY}, 32'h0);
    tick(); tick(); tick();
    chk("t1_busy_last_byte", {31'h0, BUSY}, 32'h1);
    tick();
    chk("t1_done",  {31'h0, DONE}, 32'h1);
    chk("t1_busy",  {31'h0, BUSY}, 32'h0);
    chk("t1_wcnt",  {20'h0, WORD_COUNT}, 32'h1);
    chk("t1_err",   {31'h0, ERR}, 32'h0);
    tick(); tick(); tick();
    chk("t1_done_held", {31'h0, DONE}, 32'h1);

    // 12 words back-to-back, VALID held
    do_start();
    ebase = 0;
    for (int i = 0; i < 12; i++) begin
      w = {8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
      send(w, (i == 11), 1'b0, BS, gap);
      if (i > 0) chk("t2_ready_gap", gap, 32'd4);
    end
    WD_VALID = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t2_done", {31'h0, DONE}, 32'h1);
    chk("t2_wcnt", {20'h0, WORD_COUNT}, 32'd12);
    chk("t2_err",  {31'h0, ERR}, 32'h0);

    // 13th word overflows memory
    do_start();
    chk("t3_wcnt_cleared", {20'h0, WORD_COUNT}, 32'h0);
    ebase = 0;
    for (int i = 0; i < 12; i++) begin
      send(32'hA5A5_0000 + i, 1'b0, 1'b0, BS, gap);
    end
    send(32'hDEADBEEF, 1'b0, 1'b0, 0, gap);
    WD_VALID = 1'b0;
    chk("t3_err",   {31'h0, ERR}, 32'h1);
    chk("t3_done",  {31'h0, DONE}, 32'h1);
    chk("t3_wcnt",  {20'h0, WORD_COUNT}, 32'd12);
    chk("t3_no_we", {31'h0, WE}, 32'h0);
    tick(); tick();
    chk("t3_err_held", {31'h0, ERR}, 32'h1);

    // Random VALID and ignored START pulses mid-load
    do_start();
    chk("t4_err_cleared", {31'h0, ERR}, 32'h0);
    ebase = 0;
    send(32'h0403_0201, 1'b0, 1'b1, BS, gap);
    send(32'h8877_6655, 1'b0, 1'b1, BS, gap);
    send(32'hF00D_C0DE, 1'b1, 1'b1, BS, gap);
    START = 1'b0;
    WD_VALID = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t4_done", {31'h0, DONE}, 32'h1);
    chk("t4_wcnt", {20'h0, WORD_COUNT}, 32'd3);
    chk("t4_err",  {31'h0, ERR}, 32'h0);

    // Reset during the third byte write
    do_start();
    ebase = 0;
    send(32'h1122_3344, 1'b0, 1'b0, 2, gap);
    WD_VALID = 1'b0;
    tick(); tick();
    chk("t5_we_before_rst", {31'h0, WE}, 32'h1);
    chk("t5_wa_before_rst", {20'h0, WA}, 32'd2);
    RESET_N = 1'b0;
    #1;
    check_reset_vals("t5_rst");
    tick();
    RESET_N = 1'b1;
    tick();
    chk("t5_idle_ready", {31'h0, WD_READY}, 32'h0);
    do_start();
    ebase = 0;
    send(32'hCAFEBABE, 1'b1, 1'b0, BS, gap);
    WD_VALID = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t5_done", {31'h0, DONE}, 32'h1);
    chk("t5_wcnt", {20'h0, WORD_COUNT}, 32'h1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum over two words
    do_start();
    chk("t6_csum_cleared", {24'h0, CHECKSUM}, 32'h0);
    ebase = 0;
    send(32'h01020304, 1'b0, 1'b0, BS, gap);
    send(32'hFFFFFFFF, 1'b1, 1'b0, BS, gap);
    WD_VALID = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t6_done", {31'h0, DONE}, 32'h1);
    chk("t6_csum", {24'h0, CHECKSUM}, 32'h06);
    tick();
    chk("t6_csum_stable", {24'h0, CHECKSUM}, 32'h06);
`endif

    tick(); tick();
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_imem_loader
